// File: rtl/nibble_serial_rbs_sub.sv
// Digit-serial ripple-borrow subtractor: D = A - B - B_In, one DIGIT_W-bit digit per clock, LSB first.
// Optional signed-overflow output V is built when NIBBLE_SERIAL_RBS_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | ready for an operand set; in_ready=1
// RUN   | digits 0..N-1 computed one per cycle, then one cycle to hand over to DONE
// DONE  | result held with out_valid=1 until out_ready

module nibble_serial_rbs_sub #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_In,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_Out,
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
  output logic             V,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned N  = WIDTH / DIGIT_W;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FIN  = CW'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             c_q, c_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT_W:0] sum;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
  logic             v_q, v_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  // The flop holds the carry of A + ~B, i.e. the inverted borrow.
  assign sum = {1'b0, a_q[DIGIT_W-1:0]} + {1'b0, ~b_q[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, c_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    c_d     = c_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = ~B_In;
          cnt_d   = '0;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
          v_d     = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == FIN) begin
          state_d = DONE;
        end else begin
          a_d   = a_q >> DIGIT_W;
          b_d   = b_q >> DIGIT_W;
          c_d   = sum[DIGIT_W];
          d_d   = {sum[DIGIT_W-1:0], d_q[WIDTH-1:DIGIT_W]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            bout_d = ~sum[DIGIT_W];
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
            // carry into the MSB recovered from the MSB sum bit and its operands
            v_d = (sum[DIGIT_W-1] ^ a_q[DIGIT_W-1] ^ ~b_q[DIGIT_W-1]) ^ sum[DIGIT_W];
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign B_Out     = bout_q;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_nibble_serial_rbs_sub.sv
// Directed self-checking bench for nibble_serial_rbs_sub; V is checked when NIBBLE_SERIAL_RBS_SUB_OVF_EN is defined.

module tb_nibble_serial_rbs_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, D;
  logic        B_In, in_valid, in_ready, B_Out, out_valid, out_ready;
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
  logic        V;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  nibble_serial_rbs_sub #(.WIDTH(32), .DIGIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .B_In(B_In),
    .in_valid(in_valid), .in_ready(in_ready), .D(D), .B_Out(B_Out),
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
    .V(V),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one operand set, checks latency and result,
  // optionally holding out_ready low for hold cycles first.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic ev, input int hold);
    int cyc = 0;
    while (!in_ready && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    A = a; B = b; B_In = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; B_In = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_lat"}, 32'(cyc), 32'd9);
    chk({tag, "_D"}, D, ed);
    chk({tag, "_Bout"}, 32'(B_Out), 32'(eb));
`ifdef NIBBLE_SERIAL_RBS_SUB_OVF_EN
    chk({tag, "_V"}, 32'(V), 32'(ev));
`else
    if (ev === 1'bx) $display("unreachable");
`endif
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_D"}, D, ed);
        chk({tag, "_hold_Bout"}, 32'(B_Out), 32'(eb));
        chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_idle_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ir"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; A = '0; B = '0; B_In = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_ir", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_D", D, 32'd0);
    chk("rst_Bout", 32'(B_Out), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op("t5m3",  32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
    run_op("t0m1",  32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("t0bin", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("tbp",   32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 20);

    // back-to-back with in_valid held high across both operand sets
    out_ready = 1'b1;
    A = 32'hFFFF_FFFF; B = 32'h1; B_In = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h0001_0000; B = 32'h1; B_In = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("b2b1_lat", 32'(cyc), 32'd9);
    chk("b2b1_D", D, 32'hFFFF_FFFE);
    chk("b2b1_Bout", 32'(B_Out), 32'd0);
    @(posedge clk); #1;
    chk("b2b_ov_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("b2b2_lat", 32'(cyc), 32'd9);
    chk("b2b2_D", D, 32'h0000_FFFF);
    chk("b2b2_Bout", 32'(B_Out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("b2b_nodup", 32'(out_valid), 32'd0);
    end

    // reset pulse in the middle of an operation
    A = 32'd9; B = 32'd4; B_In = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_D", D, 32'd0);
    chk("mrst_ir", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_ov", 32'(out_valid), 32'd0);
    end
    chk("mrst_idle", 32'(in_ready), 32'd1);
    run_op("t7m2", 32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0, 0);

    run_op("ovf1", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run_op("ovf0", 32'h3, 32'h5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
